dmac_write: RTL and testbench

Write-side datapath of the AXI DMA controller, the counterpart of the read path. It accepts one transfer request (destination address, burst type, byte length, beat size) from the channel scheduler. It splits the request into AXI4 write bursts of at most MAX_BURST_LEN beats that never cross a 4 KB boundary, and drives AW/W from the internal data stream. It collects every B response and reports completion and error status. One request and one burst are in flight at a time.

---
 rtl/dmac_write.sv | 174 +++++++++++++++++
 tb/tb_dmac_write.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_write.sv
// dmac_write: AXI4 write-side DMA datapath. Splits one request into bursts of at most
// MAX_BURST_LEN beats that never cross a 4 KB page. DMAC_WRITE_ERR_ABORT_EN: stop on first bad BRESP.
module dmac_write #(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req_valid,
    output logic                 wr_req_ready,
    input  logic [ADDR_WD-1:0]   wr_req_addr,
    input  logic [1:0]           wr_req_burst,
    input  logic [ADDR_WD-1:0]   wr_req_length,
    input  logic [2:0]           wr_req_size,
    output logic                 wr_done,
    output logic                 wr_err,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    input  logic [DATA_WD-1:0]   data_in,
    output logic                 m_axi_awvalid,
    output logic [ADDR_WD-1:0]   m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    input  logic                 m_axi_awready,
    output logic                 m_axi_wvalid,
    output logic [DATA_WD-1:0]   m_axi_wdata,
    output logic [DATA_WD/8-1:0] m_axi_wstrb,
    output logic                 m_axi_wlast,
    input  logic                 m_axi_wready,
    input  logic                 m_axi_bvalid,
    input  logic [1:0]           m_axi_bresp,
    output logic                 m_axi_bready
);
    localparam int STRB_WD = DATA_WD / 8;

    typedef enum logic [2:0] {IDLE, CALC, AW, W, B, DONE} state_t;

    state_t             state;
    logic [ADDR_WD-1:0] addr;
    logic [ADDR_WD-1:0] rem_beats;
    logic [ADDR_WD-1:0] rem_next;
    logic [1:0]         burst;
    logic [2:0]         size;
    logic [8:0]         burst_beats;
    logic [8:0]         beat_cnt;
    logic [8:0]         calc_beats;
    logic [12:0]        page_beats;
    logic               err;
    logic               err_next;
    logic               w_last_beat;

    // Beats left before the next 4 KB page boundary at the current address.
    assign page_beats = (13'h1000 - {1'b0, addr[11:0]}) >> size;
    assign rem_next   = rem_beats - ADDR_WD'(burst_beats);
    assign err_next   = err | (m_axi_bresp != 2'b00);

    always_comb begin
        calc_beats = 9'(MAX_BURST_LEN);
        if (burst == 2'd0 && calc_beats > 9'd16)
            calc_beats = 9'd16;
        if (burst == 2'd1 && page_beats < 13'(calc_beats))
            calc_beats = page_beats[8:0];
        if (rem_beats < ADDR_WD'(calc_beats))
            calc_beats = rem_beats[8:0];
    end

    // W channel is a straight pass-through of the internal stream while in W.
    assign w_last_beat   = (beat_cnt == burst_beats - 9'd1);
    assign m_axi_wvalid  = (state == W) && data_in_valid;
    assign data_in_ready = (state == W) && m_axi_wready;
    assign m_axi_wdata   = data_in;
    assign m_axi_wstrb   = {STRB_WD{1'b1}};
    assign m_axi_wlast   = (state == W) && w_last_beat;
    assign m_axi_bready  = (state == B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_req_ready  <= 1'b0;
            wr_done       <= 1'b0;
            wr_err        <= 1'b0;
            err           <= 1'b0;
            addr          <= '0;
            rem_beats     <= '0;
            burst         <= 2'd0;
            size          <= 3'd0;
            burst_beats   <= 9'd0;
            beat_cnt      <= 9'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= 8'd0;
            m_axi_awsize  <= 3'd0;
            m_axi_awburst <= 2'd0;
        end else begin
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            case (state)
                IDLE: begin
                    wr_req_ready <= 1'b1;
                    if (wr_req_valid && wr_req_ready) begin
                        wr_req_ready <= 1'b0;
                        addr         <= wr_req_addr;
                        burst        <= wr_req_burst;
                        size         <= wr_req_size;
                        rem_beats    <= wr_req_length >> wr_req_size;
                        err          <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    if (burst[1]) begin
                        err     <= 1'b1;
                        wr_done <= 1'b1;
                        wr_err  <= 1'b1;
                        state   <= DONE;
                    end else if (rem_beats == '0) begin
                        wr_done <= 1'b1;
                        wr_err  <= err;
                        state   <= DONE;
                    end else begin
                        burst_beats   <= calc_beats;
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= addr;
                        m_axi_awlen   <= 8'(calc_beats - 9'd1);
                        m_axi_awsize  <= size;
                        m_axi_awburst <= burst;
                        state         <= AW;
                    end
                end
                AW: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        beat_cnt      <= 9'd0;
                        state         <= W;
                    end
                end
                W: begin
                    if (data_in_valid && m_axi_wready) begin
                        if (w_last_beat)
                            state <= B;
                        else
                            beat_cnt <= beat_cnt + 9'd1;
                    end
                end
                B: begin
                    if (m_axi_bvalid) begin
                        err       <= err_next;
                        rem_beats <= rem_next;
                        if (burst == 2'd1)
                            addr <= addr + (ADDR_WD'(burst_beats) << size);
`ifdef DMAC_WRITE_ERR_ABORT_EN
                        if (rem_next == '0 || m_axi_bresp != 2'b00) begin
`else
                        if (rem_next == '0) begin
`endif
                            wr_done <= 1'b1;
                            wr_err  <= err_next;
                            state   <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                DONE: begin
                    wr_req_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmac_write.sv
// Bench for dmac_write: table of requests, spec-derived burst model feeding AW/W scoreboards,
// simple B slave with optional random stalls, plus reset corner sequences.
module tb_dmac_write;
    localparam int ADDR_WD = 32;
    localparam int DATA_WD = 32;
    localparam int MAXB    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 wr_req_valid = 1'b0, wr_req_ready;
    logic [ADDR_WD-1:0]   wr_req_addr = '0, wr_req_length = '0;
    logic [1:0]           wr_req_burst = 2'd0;
    logic [2:0]           wr_req_size = 3'd0;
    logic                 wr_done, wr_err;
    logic                 data_in_valid = 1'b0, data_in_ready;
    logic [DATA_WD-1:0]   data_in = '0;
    logic                 m_axi_awvalid, m_axi_awready = 1'b0;
    logic [ADDR_WD-1:0]   m_axi_awaddr;
    logic [7:0]           m_axi_awlen;
    logic [2:0]           m_axi_awsize;
    logic [1:0]           m_axi_awburst;
    logic                 m_axi_wvalid, m_axi_wlast, m_axi_wready = 1'b0;
    logic [DATA_WD-1:0]   m_axi_wdata;
    logic [DATA_WD/8-1:0] m_axi_wstrb;
    logic                 m_axi_bvalid = 1'b0, m_axi_bready;
    logic [1:0]           m_axi_bresp = 2'b00;

    dmac_write #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .MAX_BURST_LEN(MAXB)) dut (
        .clk(clk), .rst(rst),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_burst(wr_req_burst), .wr_req_length(wr_req_length), .wr_req_size(wr_req_size),
        .wr_done(wr_done), .wr_err(wr_err),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in(data_in),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awready(m_axi_awready),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [31:0] len;
        logic [2:0]  size;
        int          err_burst;
        bit          stall;
        int          exp_nb;
        bit          exp_err;
        int          exp_awlen0;
    } tcase_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    localparam int NCASES = 10;
    tcase_t      tc[NCASES];
    aw_t         aw_q[$];
    logic [31:0] d_q[$];
    int          exp_beats;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'hC0DE0000 + 32'(k) * 32'h00010003;
    endfunction

    // Expected AW stream and W data, derived from the burst-splitting rules.
    task automatic build_model(input tcase_t t);
        logic [31:0] a, rem, b, page;
        int idx, g;
        aw_q.delete();
        d_q.delete();
        exp_beats = 0;
        if (t.burst > 2'd1) return;
        a   = t.addr;
        rem = t.len >> t.size;
        idx = 0;
        g   = 0;
        while (rem != 0) begin
            b = (t.burst == 2'd1 || MAXB < 16) ? 32'(MAXB) : 32'd16;
            if (t.burst == 2'd1) begin
                page = (32'h1000 - {20'h0, a[11:0]}) >> t.size;
                if (page < b) b = page;
            end
            if (rem < b) b = rem;
            aw_q.push_back('{a, 8'(b - 1)});
            for (int k = 0; k < int'(b); k++) begin
                d_q.push_back(pat(g));
                g++;
            end
            exp_beats += int'(b);
            rem -= b;
            if (t.burst == 2'd1) a += b << t.size;
`ifdef DMAC_WRITE_ERR_ABORT_EN
            if (idx == t.err_burst) break;
`endif
            idx++;
        end
    endtask

    task automatic run_case(input int ci);
        tcase_t t;
        aw_t cur;
        int cyc, acc, sent, wbeat, nb, b_pend, b_idx, last_b, first_aw, done_cyc;
        bit got_done, hold, aw_open, aw_wait;
        logic [39:0] h_aw;
        t = tc[ci];
        cyc = 0; acc = -1; sent = 0; wbeat = 0; nb = 0; b_pend = 0; b_idx = 0;
        last_b = -100; first_aw = -1; done_cyc = -1;
        got_done = 0; hold = 0; aw_open = 0; aw_wait = 0; h_aw = '0;
        cur = '{32'h0, 8'h0};
        build_model(t);
        wr_req_addr   = t.addr;
        wr_req_burst  = t.burst;
        wr_req_length = t.len;
        wr_req_size   = t.size;
        while (cyc < 3000 && !got_done) begin
            @(negedge clk);
            wr_req_valid  = (acc < 0);
            m_axi_awready = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            data_in_valid = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            data_in       = pat(sent);
            m_axi_bvalid  = (b_pend > 0) && (t.stall ? 1'($urandom_range(0, 1)) : 1'b1);
            m_axi_bresp   = (b_idx == t.err_burst) ? 2'b10 : 2'b00;
            #1;
            if (wr_req_valid && wr_req_ready) acc = cyc;
            if (hold) chk("aw_stable", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, h_aw});
            hold = m_axi_awvalid && !m_axi_awready;
            h_aw = {m_axi_awaddr, m_axi_awlen};
            if (m_axi_awvalid && first_aw < 0) first_aw = cyc;
            if (m_axi_awvalid && aw_wait) begin
                if (!t.stall) chk("b_to_aw", cyc - last_b, 2);
                aw_wait = 0;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                nb++;
                aw_open = 1;
                wbeat = 0;
                chk("aw_expected", aw_q.size() > 0, 1);
                if (aw_q.size() > 0) begin
                    cur = aw_q.pop_front();
                    chk("awaddr", m_axi_awaddr, cur.addr);
                    chk("awlen", m_axi_awlen, cur.len);
                    chk("awsize", m_axi_awsize, t.size);
                    chk("awburst", m_axi_awburst, t.burst);
                    if (nb == 1) chk("awlen_first", m_axi_awlen, t.exp_awlen0);
                end
            end
            if (m_axi_wvalid) chk("w_after_aw", aw_open, 1);
            if (m_axi_wvalid && m_axi_wready) begin
                chk("data_in_ready", data_in_ready, 1);
                chk("w_expected", d_q.size() > 0, 1);
                if (d_q.size() > 0) chk("wdata", m_axi_wdata, d_q.pop_front());
                chk("wstrb", m_axi_wstrb, 4'hF);
                chk("wlast", m_axi_wlast, wbeat == int'(cur.len));
                sent++;
                if (m_axi_wlast) begin
                    b_pend++;
                    aw_open = 0;
                    wbeat = 0;
                end else begin
                    wbeat++;
                end
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend--;
                b_idx++;
                last_b = cyc;
                aw_wait = 1;
            end
            if (wr_done) begin
                got_done = 1;
                done_cyc = cyc;
                chk("wr_err", wr_err, t.exp_err);
            end
            cyc++;
        end
        wr_req_valid  = 1'b0;
        m_axi_bvalid  = 1'b0;
        data_in_valid = 1'b0;
        chk("done_seen", got_done, 1);
        chk("n_bursts", nb, t.exp_nb);
        chk("aw_left", aw_q.size(), 0);
        chk("w_left", d_q.size(), 0);
        chk("beats", sent, exp_beats);
        if (t.exp_nb > 0) chk("b_to_done", done_cyc - last_b, 1);
        else chk("accept_to_done", done_cyc - acc, 2);
        if (!t.stall && t.exp_nb > 0) chk("accept_to_aw", first_aw - acc, 2);
        @(negedge clk);
        #1;
        chk("done_pulse", wr_done, 0);
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!wr_req_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, wr_req_ready, 1);
    endtask

    initial begin
`ifdef DMAC_WRITE_ERR_ABORT_EN
        localparam int ERR_NB = 2;
`else
        localparam int ERR_NB = 3;
`endif
        tc[0] = '{32'h0000_1000, 2'd1, 32'd64,  3'd2, -1, 1'b0, 1, 1'b0, 15};
        tc[1] = '{32'h0000_0FF8, 2'd1, 32'd32,  3'd2, -1, 1'b0, 2, 1'b0, 1};
        tc[2] = '{32'h0000_2000, 2'd0, 32'd80,  3'd2, -1, 1'b0, 2, 1'b0, 15};
        tc[3] = '{32'h0000_3000, 2'd1, 32'd256, 3'd2, -1, 1'b1, 4, 1'b0, 15};
        tc[4] = '{32'h0000_4000, 2'd1, 32'd192, 3'd2, 1,  1'b0, ERR_NB, 1'b1, 15};
        tc[5] = '{32'h0000_5000, 2'd1, 32'd0,   3'd2, -1, 1'b0, 0, 1'b0, 0};
        tc[6] = '{32'h0000_6000, 2'd2, 32'd16,  3'd2, -1, 1'b0, 0, 1'b1, 0};
        tc[7] = '{32'h0000_0FFC, 2'd1, 32'd8,   3'd1, -1, 1'b0, 2, 1'b0, 1};
        tc[8] = '{32'h0000_7001, 2'd1, 32'd5,   3'd0, -1, 1'b1, 1, 1'b0, 4};
        tc[9] = '{32'hFFFF_FFF8, 2'd1, 32'd16,  3'd2, -1, 1'b0, 2, 1'b0, 1};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs",
            {wr_req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, data_in_ready,
             wr_done, wr_err, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst}, '0);
        rst = 1'b0;
        wait_ready("ready_after_reset");

        for (int i = 0; i < NCASES; i++) run_case(i);

        // Reset in the middle of a burst drops everything; the next request runs clean.
        wr_req_addr = 32'h8000; wr_req_burst = 2'd1; wr_req_length = 32'd64; wr_req_size = 3'd2;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; data_in_valid = 1'b1; wr_req_valid = 1'b1;
        @(negedge clk);
        wr_req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("mid_burst_in_w", m_axi_wvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_burst_reset",
            {m_axi_awvalid, m_axi_wvalid, m_axi_bready, data_in_ready, wr_done, wr_req_ready}, '0);
        rst = 1'b0;
        data_in_valid = 1'b0;
        wait_ready("ready_after_mid_reset");
        run_case(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
